// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline control unit and the hazard unit:
// FSM encodings, NOP encoding, control-transfer opcodes and the stage-control bundle.
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DSTALL = 2'd1,
    MWAIT  = 2'd2
  } state_e;

  // sll $0,$0,0 -- the value a flushed or bubbled pipeline register holds
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] FUNCT_JR = 6'h08;

  typedef struct packed {
    logic pc_en;
    logic fd_en;
    logic fd_flush;
    logic dx_en;
    logic dx_bubble;
    logic xm_en;
    logic mw_en;
  } ctrl_t;

  localparam ctrl_t CTRL_FREEZE = 7'b000_0000;

  function automatic ctrl_t ctrl_flow(input logic flush);
    ctrl_t c;
    c           = CTRL_FREEZE;
    c.pc_en     = 1'b1;
    c.fd_en     = 1'b1;
    c.fd_flush  = flush;
    c.dx_en     = 1'b1;
    c.xm_en     = 1'b1;
    c.mw_en     = 1'b1;
    return c;
  endfunction

  // Hold PC and IF/ID, push a NOP into EX, let the older instructions drain.
  function automatic ctrl_t ctrl_load_use();
    ctrl_t c;
    c           = CTRL_FREEZE;
    c.dx_en     = 1'b1;
    c.dx_bubble = 1'b1;
    c.xm_en     = 1'b1;
    c.mw_en     = 1'b1;
    return c;
  endfunction

  function automatic logic is_ctrl_transfer(input logic [5:0] opcode, input logic [5:0] funct);
    logic hit;
    hit = 1'b0;
    case (opcode)
      OP_BEQ, OP_BNE, OP_J, OP_JAL: hit = 1'b1;
      OP_RTYPE:                     hit = (funct == FUNCT_JR);
      default:                      hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/pipe_perf_cnt.sv
// Saturating performance counter: counts cycles with inc=1 and sticks at all ones.
module pipe_perf_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + CNT_ONE;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control for the 5-stage MIPS core: turns memory-wait, load-use and
// decode-redirect requests into per-stage enables, flush and bubble controls.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 64,
  parameter int MAX_DSTALL  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             d_stall,
  input  logic             d_redirect,
  input  logic             dmem_req,
  input  logic             dmem_ack,
  output logic             pc_en,
  output logic             fd_en,
  output logic             fd_flush,
  output logic             dx_en,
  output logic             dx_bubble,
  output logic             xm_en,
  output logic             mw_en,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             mem_err,
  output logic             hazard_err
);

  localparam int MT_W = $clog2(MEM_TIMEOUT + 1);
  localparam int DS_W = $clog2(MAX_DSTALL + 2);

  localparam logic [MT_W-1:0] MT_MAX = MT_W'(MEM_TIMEOUT);
  localparam logic [MT_W-1:0] MT_ONE = {{(MT_W-1){1'b0}}, 1'b1};
  localparam logic [DS_W-1:0] DS_LIM = DS_W'(MAX_DSTALL);
  localparam logic [DS_W-1:0] DS_MAX = DS_W'(MAX_DSTALL + 1);
  localparam logic [DS_W-1:0] DS_ONE = {{(DS_W-1){1'b0}}, 1'b1};

  state_e          state_q;
  state_e          state_d;
  logic [MT_W-1:0] mwait_q;
  logic [MT_W-1:0] mwait_d;
  logic [DS_W-1:0] dstall_q;
  logic [DS_W-1:0] dstall_d;
  logic            in_mwait;
  logic            mem_wait;
  ctrl_t           ctrl;

  // Once in MWAIT the access is outstanding until acked, so only ack releases it.
  always_comb begin
    in_mwait = 1'b0;
    case (state_q)
      MWAIT:       in_mwait = 1'b1;
      RUN, DSTALL: in_mwait = 1'b0;
      default:     in_mwait = 1'b0;
    endcase
    mem_wait = (dmem_req & ~dmem_ack) | (in_mwait & ~dmem_ack);
  end

  // Mealy decision: memory wait beats load-use, which masks an unresolved redirect.
  always_comb begin
    ctrl    = CTRL_FREEZE;
    state_d = RUN;
    if (mem_wait) begin
      ctrl    = CTRL_FREEZE;
      state_d = MWAIT;
    end else if (d_stall) begin
      ctrl    = ctrl_load_use();
      state_d = DSTALL;
    end else if (d_redirect) begin
      ctrl    = ctrl_flow(1'b1);
      state_d = RUN;
    end else begin
      ctrl    = ctrl_flow(1'b0);
      state_d = RUN;
    end
    if (!rst_n) begin
      ctrl = CTRL_FREEZE;
    end
  end

  always_comb begin
    mwait_d  = '0;
    dstall_d = '0;
    if (mem_wait) begin
      mwait_d = (mwait_q == MT_MAX) ? mwait_q : mwait_q + MT_ONE;
    end
    // A frozen pipeline neither extends nor breaks a run of load-use stalls.
    if (mem_wait) begin
      dstall_d = dstall_q;
    end else if (d_stall) begin
      dstall_d = (dstall_q == DS_MAX) ? dstall_q : dstall_q + DS_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      mwait_q    <= '0;
      dstall_q   <= '0;
      mem_err    <= 1'b0;
      hazard_err <= 1'b0;
    end else begin
      state_q  <= state_d;
      mwait_q  <= mwait_d;
      dstall_q <= dstall_d;
      if (mwait_d == MT_MAX) begin
        mem_err <= 1'b1;
      end
      if (dstall_d > DS_LIM) begin
        hazard_err <= 1'b1;
      end
    end
  end

  assign pc_en     = ctrl.pc_en;
  assign fd_en     = ctrl.fd_en;
  assign fd_flush  = ctrl.fd_flush;
  assign dx_en     = ctrl.dx_en;
  assign dx_bubble = ctrl.dx_bubble;
  assign xm_en     = ctrl.xm_en;
  assign mw_en     = ctrl.mw_en;
  assign state     = state_q;

  pipe_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (~ctrl.pc_en),
    .count (stall_cnt)
  );

  pipe_perf_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (ctrl.fd_flush),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: vector table, directed multi-cycle sequences and a
// randomized run against a cycle-level reference model of the control rules.
module tb_pipe_ctrl;

  localparam int CNT_W       = 4;
  localparam int MEM_TIMEOUT = 4;
  localparam int MAX_DSTALL  = 2;
  localparam int CNT_SAT     = (1 << CNT_W) - 1;

  // {pc_en, fd_en, fd_flush, dx_en, dx_bubble, xm_en, mw_en}
  localparam logic [6:0] C_ALL = 7'b1101011;
  localparam logic [6:0] C_FL  = 7'b1111011;
  localparam logic [6:0] C_LU  = 7'b0001111;
  localparam logic [6:0] C_FRZ = 7'b0000000;

  logic             clk;
  logic             rst_n;
  logic             d_stall, d_redirect, dmem_req, dmem_ack;
  logic             pc_en, fd_en, fd_flush, dx_en, dx_bubble, xm_en, mw_en;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic             mem_err, hazard_err;
  logic [6:0]       ctrl_vec;

  int n_cmp = 0;
  int n_bad = 0;

  pipe_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT), .MAX_DSTALL(MAX_DSTALL)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .d_stall    (d_stall),
    .d_redirect (d_redirect),
    .dmem_req   (dmem_req),
    .dmem_ack   (dmem_ack),
    .pc_en      (pc_en),
    .fd_en      (fd_en),
    .fd_flush   (fd_flush),
    .dx_en      (dx_en),
    .dx_bubble  (dx_bubble),
    .xm_en      (xm_en),
    .mw_en      (mw_en),
    .state      (state),
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt),
    .mem_err    (mem_err),
    .hazard_err (hazard_err)
  );

  assign ctrl_vec = {pc_en, fd_en, fd_flush, dx_en, dx_bubble, xm_en, mw_en};

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  int m_state, m_wait, m_run, m_stall_cnt, m_flush_cnt;
  bit m_mem_err, m_haz_err;

  task automatic model_reset();
    m_state = 0; m_wait = 0; m_run = 0;
    m_stall_cnt = 0; m_flush_cnt = 0;
    m_mem_err = 0; m_haz_err = 0;
  endtask

  task automatic model_cycle(input logic rq, input logic ak, input logic st,
                             input logic rd, output logic [6:0] ec);
    bit frozen;
    frozen = (rq && !ak) || (m_state == 2 && !ak);
    if (frozen)  ec = C_FRZ;
    else if (st) ec = C_LU;
    else if (rd) ec = C_FL;
    else         ec = C_ALL;
    if (!ec[6] && m_stall_cnt < CNT_SAT) m_stall_cnt++;
    if (ec[4] && m_flush_cnt < CNT_SAT)  m_flush_cnt++;
    if (frozen) begin
      m_wait++;
      if (m_wait >= MEM_TIMEOUT) m_mem_err = 1;
    end else begin
      m_wait = 0;
      m_run  = st ? m_run + 1 : 0;
      if (m_run > MAX_DSTALL) m_haz_err = 1;
    end
    m_state = frozen ? 2 : (st ? 1 : 0);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks: inputs change just after posedge, outputs sampled at negedge
  task automatic drive(input logic rq, input logic ak, input logic st, input logic rd);
    @(posedge clk);
    #1;
    dmem_req = rq; dmem_ack = ak; d_stall = st; d_redirect = rd;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    dmem_req = 0; dmem_ack = 0; d_stall = 0; d_redirect = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic       rq, ak, st, rd;
    logic [6:0] ctrl;
    logic [1:0] st_reg;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic [6:0] ec;
    int         exp_state, exp_sc, exp_fc;
    bit         exp_me, exp_he;

    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, C_ALL, 2'd0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, C_FL,  2'd0};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, C_ALL, 2'd0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, C_ALL, 2'd0};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, C_LU,  2'd0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, C_ALL, 2'd1};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, C_FRZ, 2'd0};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 1'b1, C_FRZ, 2'd2};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, C_FL,  2'd2};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, C_LU,  2'd0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1, C_FL,  2'd1};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, C_ALL, 2'd0};

    rst_n = 1'b0;
    dmem_req = 0; dmem_ack = 0; d_stall = 0; d_redirect = 0;
    #2;
    check("reset_state", state, 0);
    check("reset_ctrl", ctrl_vec, C_FRZ);
    check("reset_cnt", {stall_cnt, flush_cnt}, 0);
    check("reset_err", {mem_err, hazard_err}, 0);

    // vector table
    do_reset();
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].rq, vecs[i].ak, vecs[i].st, vecs[i].rd);
      check($sformatf("tbl%0d_ctrl", i), ctrl_vec, vecs[i].ctrl);
      check($sformatf("tbl%0d_state", i), state, vecs[i].st_reg);
    end
    check("tbl_stall_cnt", stall_cnt, 4);
    check("tbl_flush_cnt", flush_cnt, 3);
    check("tbl_errs", {mem_err, hazard_err}, 0);

    // reset in the middle of a memory wait
    do_reset();
    for (int i = 0; i < 5; i++) drive(1, 0, 0, 0);
    check("mw5_ctrl", ctrl_vec, C_FRZ);
    check("mw5_state", state, 2);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_state", state, 0);
    check("rst_mid_ctrl", ctrl_vec, C_FRZ);
    check("rst_mid_cnt", {stall_cnt, flush_cnt}, 0);
    check("rst_mid_err", mem_err, 0);
    drive(0, 0, 0, 0);
    check("rst_hold_ctrl", ctrl_vec, C_FRZ);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_release_ctrl", ctrl_vec, C_ALL);

    // single load-use stall
    do_reset();
    drive(0, 0, 1, 0);
    check("lu_pc_fd", {pc_en, fd_en}, 0);
    check("lu_bubble", dx_bubble, 1);
    drive(0, 0, 0, 0);
    check("lu_after_ctrl", ctrl_vec, C_ALL);
    check("lu_stall_cnt", stall_cnt, 1);

    // redirect arriving during a stall is deferred until the stall clears
    do_reset();
    drive(0, 0, 1, 1);
    check("rds_n_flush", fd_flush, 0);
    drive(0, 0, 0, 1);
    check("rds_n1_flush_pc", {fd_flush, pc_en}, 2'b11);
    drive(0, 0, 0, 0);
    check("rds_flush_cnt", flush_cnt, 1);

    // memory wait ending in a load-use stall
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0);
      check($sformatf("mw_frz%0d", i), ctrl_vec, C_FRZ);
    end
    drive(1, 1, 1, 0);
    check("mw_ack_ctrl", ctrl_vec, C_LU);
    drive(0, 0, 0, 0);
    check("mw_next_state", state, 1);
    check("mw_stall_cnt", stall_cnt, 4);

    // memory timeout
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      drive(1, 0, 0, 0);
      check($sformatf("to_cyc%0d_mem_err", i), mem_err, (i >= 5) ? 1 : 0);
    end
    drive(1, 1, 0, 0);
    check("to_ack_ctrl", ctrl_vec, C_ALL);
    drive(0, 0, 0, 0);
    check("to_sticky", mem_err, 1);
    check("to_state", state, 0);

    // stall deadlock and counter saturation
    do_reset();
    for (int i = 1; i <= 20; i++) begin
      drive(0, 0, 1, 0);
      if (i == 3 || i == 4) check($sformatf("dl_cyc%0d_hazard_err", i), hazard_err, (i == 4) ? 1 : 0);
    end
    drive(0, 0, 0, 0);
    check("sat_stall_cnt", stall_cnt, CNT_SAT);
    check("dl_sticky", hazard_err, 1);

    // randomized run against the reference model
    for (int blk = 0; blk < 4; blk++) begin
      do_reset();
      for (int c = 0; c < 100; c++) begin
        logic rq, ak, st, rd;
        rq = (m_state == 2) ? 1'b1 : ($urandom_range(0, 9) < 3);
        ak = (m_state == 2) ? ($urandom_range(0, 3) == 0) : 1'($urandom_range(0, 1));
        st = ($urandom_range(0, 9) < 3);
        rd = ($urandom_range(0, 3) == 0);
        drive(rq, ak, st, rd);
        exp_state = m_state; exp_sc = m_stall_cnt; exp_fc = m_flush_cnt;
        exp_me = m_mem_err; exp_he = m_haz_err;
        model_cycle(rq, ak, st, rd, ec);
        check("rnd_ctrl", ctrl_vec, ec);
        check("rnd_state", state, exp_state);
        check("rnd_stall_cnt", stall_cnt, exp_sc);
        check("rnd_flush_cnt", flush_cnt, exp_fc);
        check("rnd_errs", {mem_err, hazard_err}, {exp_me, exp_he});
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
